// File: rtl/iw_stage.sv
// Instruction-wait stage: holds one fetch between IF and ID, waits for its SRAM
// response if needed, and drops responses made stale by flushes.
module iw_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic        inst_valid_in,
  input  logic [31:0] inst_in,
  input  logic        has_exception_in,
  input  logic [5:0]  ecode_in,
  input  logic [8:0]  esubcode_in,
  input  logic        discard_in,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  input  logic        ex_flush,
  input  logic        ertn_flush,
  input  logic        br_taken,
  input  logic        tlb_flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic        has_exception_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic        IW_inst_valid,
  output logic [1:0]  discard
);

  // EMPTY: !valid; WAIT: valid && !got; FULL: valid && got
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } ent_e;

  ent_e        st_q, st_d;
  logic        flush;
  logic        handover;
  logic        drop;
  logic        capture;
  logic        retire;
  logic [1:0]  inc;
  logic [2:0]  disc_sum;
  logic [1:0]  disc_d;

  assign flush    = ex_flush | ertn_flush | br_taken | tlb_flush;
  assign in_ready = (st_q == EMPTY) || ((st_q == FULL) && out_ready);
  assign handover = in_valid && in_ready && !flush;
  assign drop     = data_ok && (discard != 2'd0);
  assign capture  = data_ok && !drop && (st_q == WAIT);
  assign retire   = (st_q == FULL) && out_ready;

  assign out_valid     = (st_q == FULL);
  assign IW_inst_valid = (st_q == FULL);

  always_comb begin
    st_d = st_q;
    if (flush)
      st_d = EMPTY;
    else if (handover)
      st_d = inst_valid_in ? FULL : WAIT;
    else if (capture)
      st_d = FULL;
    else if (retire)
      st_d = EMPTY;
  end

  // Each term is one issued request whose response will now arrive unwanted.
  always_comb begin
    inc = '0;
    if (flush)
      inc = {1'b0, (st_q == WAIT) && !capture}
          + {1'b0, discard_in}
          + {1'b0, in_valid && !inst_valid_in};
  end

  always_comb begin
    disc_sum = {1'b0, discard} + {1'b0, inc} - {2'b00, drop};
    disc_d   = (disc_sum > 3'd3) ? 2'd3 : disc_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= EMPTY;
      discard <= '0;
    end else begin
      st_q    <= st_d;
      discard <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC_out            <= '0;
      inst_out          <= '0;
      has_exception_out <= 1'b0;
      ecode_out         <= '0;
      esubcode_out      <= '0;
    end else if (handover) begin
      PC_out            <= pc_in;
      inst_out          <= inst_in;
      has_exception_out <= has_exception_in;
      ecode_out         <= ecode_in;
      esubcode_out      <= esubcode_in;
    end else if (capture && !flush) begin
      inst_out          <= rdata;
    end
  end

endmodule
